// File: rtl/approx_adder_err_monitor.sv
// -----------------------------------------------------------------------------
// approx_adder_err_monitor
//
// Sits beside an approximate adder and measures its error on-chip. Each
// accepted sample is an (approx_sum, exact_sum) pair. Over a programmable
// window of samples the block accumulates:
//   - the sample count and the count of samples with a nonzero error,
//   - the sum of absolute errors (SAE),
//   - the sum of squared errors (SSE),
//   - the largest absolute error and the index of the first sample that
//     reached it.
// MSE and SNR are derived off-chip from sse / n_samples.
//
// Ports
//   Clk, Rst            clock; synchronous active-high reset
//   start, win_len      begin a window of win_len samples (0 means 1), IDLE only
//   in_valid, in_ready  sample handshake; a transfer is in_valid & in_ready
//   approx_sum          W+1 bit output of the adder under test
//   exact_sum           W+1 bit reference sum
//   done, res_ack       results final while done=1; res_ack returns to IDLE
//   n_samples, n_err    accepted samples / samples with nonzero error
//   sae, sse            saturating error sums
//   max_ae, max_idx     largest error and the 0-based index of its first hit
//   ovf                 sticky saturation flag for SAE or SSE, cleared by start
//
// Pipeline: S1 registers |approx - exact|, S2 registers its square and
// updates n_err / sae / max, S3 adds the square into sse. The FSM drains
// for two cycles after the last transfer, so done rises exactly when the
// last sample has left S3.
// -----------------------------------------------------------------------------
module approx_adder_err_monitor #(
  parameter int W     = 32,
  parameter int CNT_W = 32,
  parameter int SAE_W = 64,
  parameter int SSE_W = 96
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   win_len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W:0]         approx_sum,
  input  logic [W:0]         exact_sum,
  output logic               done,
  input  logic               res_ack,
  output logic [CNT_W-1:0]   n_samples,
  output logic [CNT_W-1:0]   n_err,
  output logic [SAE_W-1:0]   sae,
  output logic [SSE_W-1:0]   sse,
  output logic [W:0]         max_ae,
  output logic [CNT_W-1:0]   max_idx,
  output logic               ovf
);

  // Width of a squared error.
  localparam int SQ_W      = 2 * W + 2;
  // Adders are one bit wider than the larger operand so a carry past the
  // accumulator width is visible and can trigger saturation. SSE_W may be
  // narrower than SQ_W, in which case a single large square saturates.
  localparam int SAE_SUM_W = ((SAE_W > (W + 1)) ? SAE_W : (W + 1)) + 1;
  localparam int SSE_SUM_W = ((SSE_W > SQ_W) ? SSE_W : SQ_W) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Absolute difference of two unsigned sums, computed without wrap.
  function automatic logic [W:0] abs_diff(input logic [W:0] a, input logic [W:0] b);
    logic [W:0] r;
    if (a >= b) begin
      r = a - b;
    end else begin
      r = b - a;
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State and next-state signals
  // ---------------------------------------------------------------------------
  state_t             state_q,    state_d;
  logic               drain_q,    drain_d;
  logic [CNT_W-1:0]   win_len_q,  win_len_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               done_q,     done_d;

  logic               s1_vld_q,   s1_vld_d;
  logic [W:0]         s1_ae_q,    s1_ae_d;
  logic [CNT_W-1:0]   s1_idx_q,   s1_idx_d;

  logic               s2_vld_q,   s2_vld_d;
  logic [SQ_W-1:0]    s2_sq_q,    s2_sq_d;

  logic [CNT_W-1:0]   n_err_q,    n_err_d;
  logic [SAE_W-1:0]   sae_q,      sae_d;
  logic [SSE_W-1:0]   sse_q,      sse_d;
  logic [W:0]         max_ae_q,   max_ae_d;
  logic [CNT_W-1:0]   max_idx_q,  max_idx_d;
  logic               ovf_q,      ovf_d;

  logic               xfer_s;
  logic               last_s;
  logic               start_s;
  logic [SAE_SUM_W-1:0] sae_sum_s;
  logic [SSE_SUM_W-1:0] sse_sum_s;
  logic               sae_sat_s;
  logic               sse_sat_s;

  // Handshake decode; in_ready_q is high exactly while the FSM is in RUN.
  always_comb begin
    xfer_s  = in_valid & in_ready_q;
    last_s  = xfer_s && ((cnt_q + {{(CNT_W-1){1'b0}}, 1'b1}) == win_len_q);
    start_s = start && (state_q == ST_IDLE);
  end

  // Saturating accumulator sums for the S2 (SAE) and S3 (SSE) stages.
  always_comb begin
    sae_sum_s = SAE_SUM_W'(sae_q) + SAE_SUM_W'(s1_ae_q);
    sse_sum_s = SSE_SUM_W'(sse_q) + SSE_SUM_W'(s2_sq_q);
    sae_sat_s = |sae_sum_s[SAE_SUM_W-1:SAE_W];
    sse_sat_s = |sse_sum_s[SSE_SUM_W-1:SSE_W];
  end

  // FSM next state: IDLE -> RUN -> DRAIN (two cycles) -> DONE -> IDLE.
  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    win_len_d = win_len_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          if (win_len == {CNT_W{1'b0}}) begin
            win_len_d = {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            win_len_d = win_len;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_d = ST_DRAIN;
          drain_d = 1'b0;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        // Second DRAIN cycle is the one in which S3 absorbs the last sample.
        if (drain_q) begin
          state_d = ST_DONE;
          drain_d = 1'b0;
        end else begin
          drain_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (res_ack) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        drain_d = 1'b0;
      end
    endcase
    in_ready_d = (state_d == ST_RUN);
    done_d     = (state_d == ST_DONE);
  end

  // Datapath next state: S1 capture, S2 count/SAE/max update, S3 SSE update.
  always_comb begin
    cnt_d     = cnt_q;
    s1_vld_d  = xfer_s;
    s1_ae_d   = s1_ae_q;
    s1_idx_d  = s1_idx_q;
    s2_vld_d  = s1_vld_q;
    s2_sq_d   = s2_sq_q;
    n_err_d   = n_err_q;
    sae_d     = sae_q;
    sse_d     = sse_q;
    max_ae_d  = max_ae_q;
    max_idx_d = max_idx_q;
    ovf_d     = ovf_q;

    // S1: capture the absolute error and the sample's window index.
    if (xfer_s) begin
      s1_ae_d  = abs_diff(approx_sum, exact_sum);
      s1_idx_d = cnt_q;
      cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d    = cnt_q;
    end

    // S2: square, error count, SAE and first-reached maximum.
    if (s1_vld_q) begin
      s2_sq_d = SQ_W'(s1_ae_q) * SQ_W'(s1_ae_q);
      if (s1_ae_q != {(W+1){1'b0}}) begin
        n_err_d = n_err_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        n_err_d = n_err_q;
      end
      if (sae_sat_s) begin
        sae_d = {SAE_W{1'b1}};
        ovf_d = 1'b1;
      end else begin
        sae_d = sae_sum_s[SAE_W-1:0];
      end
      // Strict compare: a tie keeps the earlier index.
      if (s1_ae_q > max_ae_q) begin
        max_ae_d  = s1_ae_q;
        max_idx_d = s1_idx_q;
      end else begin
        max_ae_d  = max_ae_q;
      end
    end else begin
      s2_sq_d = s2_sq_q;
    end

    // S3: accumulate the squared error. ovf_d may already be set by S2.
    if (s2_vld_q) begin
      if (sse_sat_s) begin
        sse_d = {SSE_W{1'b1}};
        ovf_d = 1'b1;
      end else begin
        sse_d = sse_sum_s[SSE_W-1:0];
      end
    end else begin
      sse_d = sse_q;
    end

    // A taken start clears the previous window's results. The pipeline is
    // empty in IDLE, so nothing above is active in the same cycle.
    if (start_s) begin
      cnt_d     = {CNT_W{1'b0}};
      n_err_d   = {CNT_W{1'b0}};
      sae_d     = {SAE_W{1'b0}};
      sse_d     = {SSE_W{1'b0}};
      max_ae_d  = {(W+1){1'b0}};
      max_idx_d = {CNT_W{1'b0}};
      ovf_d     = 1'b0;
    end else begin
      ovf_d     = ovf_d;
    end
  end

  // State register; Rst aborts any window and flushes the pipeline.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= ST_IDLE;
      drain_q    <= 1'b0;
      win_len_q  <= {CNT_W{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
      in_ready_q <= 1'b0;
      done_q     <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_ae_q    <= {(W+1){1'b0}};
      s1_idx_q   <= {CNT_W{1'b0}};
      s2_vld_q   <= 1'b0;
      s2_sq_q    <= {SQ_W{1'b0}};
      n_err_q    <= {CNT_W{1'b0}};
      sae_q      <= {SAE_W{1'b0}};
      sse_q      <= {SSE_W{1'b0}};
      max_ae_q   <= {(W+1){1'b0}};
      max_idx_q  <= {CNT_W{1'b0}};
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      win_len_q  <= win_len_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      done_q     <= done_d;
      s1_vld_q   <= s1_vld_d;
      s1_ae_q    <= s1_ae_d;
      s1_idx_q   <= s1_idx_d;
      s2_vld_q   <= s2_vld_d;
      s2_sq_q    <= s2_sq_d;
      n_err_q    <= n_err_d;
      sae_q      <= sae_d;
      sse_q      <= sse_d;
      max_ae_q   <= max_ae_d;
      max_idx_q  <= max_idx_d;
      ovf_q      <= ovf_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign done      = done_q;
  assign n_samples = cnt_q;
  assign n_err     = n_err_q;
  assign sae       = sae_q;
  assign sse       = sse_q;
  assign max_ae    = max_ae_q;
  assign max_idx   = max_idx_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_approx_adder_err_monitor.sv
// Bench for approx_adder_err_monitor. Two instances share all inputs: one
// with default widths and one with narrow SAE/SSE accumulators so that
// saturation can be reached. Expected window results are pushed to a
// scoreboard when a window is driven and popped when done rises.
module tb_approx_adder_err_monitor;

  logic        Clk;
  logic        Rst;
  logic        start;
  logic [31:0] win_len;
  logic        in_valid;
  logic [32:0] approx_sum;
  logic [32:0] exact_sum;
  logic        res_ack;

  logic        a_in_ready, a_done, a_ovf;
  logic [31:0] a_n_samples, a_n_err, a_max_idx;
  logic [63:0] a_sae;
  logic [95:0] a_sse;
  logic [32:0] a_max_ae;

  logic        b_in_ready, b_done, b_ovf;
  logic [31:0] b_n_samples, b_n_err, b_max_idx;
  logic [33:0] b_sae;
  logic [63:0] b_sse;
  logic [32:0] b_max_ae;

  approx_adder_err_monitor #(.W(32), .CNT_W(32), .SAE_W(64), .SSE_W(96)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .win_len(win_len),
    .in_valid(in_valid), .in_ready(a_in_ready),
    .approx_sum(approx_sum), .exact_sum(exact_sum),
    .done(a_done), .res_ack(res_ack),
    .n_samples(a_n_samples), .n_err(a_n_err), .sae(a_sae), .sse(a_sse),
    .max_ae(a_max_ae), .max_idx(a_max_idx), .ovf(a_ovf)
  );

  approx_adder_err_monitor #(.W(32), .CNT_W(32), .SAE_W(34), .SSE_W(64)) dut_sat (
    .Clk(Clk), .Rst(Rst), .start(start), .win_len(win_len),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .approx_sum(approx_sum), .exact_sum(exact_sum),
    .done(b_done), .res_ack(res_ack),
    .n_samples(b_n_samples), .n_err(b_n_err), .sae(b_sae), .sse(b_sse),
    .max_ae(b_max_ae), .max_idx(b_max_idx), .ovf(b_ovf)
  );

  typedef struct {
    logic [127:0] n, nerr, sae, sse, mae, midx, ovf, sae2, sse2, ovf2;
  } exp_t;

  localparam logic [127:0] SAE1_MAX = {64'd0, {64{1'b1}}};
  localparam logic [127:0] SSE1_MAX = {32'd0, {96{1'b1}}};
  localparam logic [127:0] SAE2_MAX = {94'd0, {34{1'b1}}};
  localparam logic [127:0] SSE2_MAX = {64'd0, {64{1'b1}}};

  exp_t        sb[$];
  logic [32:0] ap_a[$];
  logic [32:0] ex_a[$];
  bit          vpat[$];
  bit          misuse;
  bit          hold_valid;
  int          n_checks;
  int          n_errors;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, expv);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  // Reference model of one window over the first n queued samples.
  function automatic exp_t model(input int n);
    exp_t e;
    logic [127:0] a, b, ae, sq;
    e = '{default: 128'd0};
    for (int i = 0; i < n; i++) begin
      a  = 128'(ap_a[i]);
      b  = 128'(ex_a[i]);
      ae = (a >= b) ? (a - b) : (b - a);
      sq = ae * ae;
      if (ae != 128'd0) e.nerr = e.nerr + 128'd1;
      if (ae > e.mae) begin
        e.mae  = ae;
        e.midx = 128'(i);
      end
      e.sae = e.sae + ae;
      if (e.sae > SAE1_MAX) begin e.sae = SAE1_MAX; e.ovf = 128'd1; end
      e.sse = e.sse + sq;
      if (e.sse > SSE1_MAX) begin e.sse = SSE1_MAX; e.ovf = 128'd1; end
      e.sae2 = e.sae2 + ae;
      if (e.sae2 > SAE2_MAX) begin e.sae2 = SAE2_MAX; e.ovf2 = 128'd1; end
      e.sse2 = e.sse2 + sq;
      if (e.sse2 > SSE2_MAX) begin e.sse2 = SSE2_MAX; e.ovf2 = 128'd1; end
    end
    e.n = 128'(n);
    return e;
  endfunction

  task automatic compare_results(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check_val({tag, "_sb_empty"}, 128'd1, 128'd0);
    end else begin
      e = sb.pop_front();
      check_val({tag, "_nsamp"},  128'(a_n_samples), e.n);
      check_val({tag, "_nerr"},   128'(a_n_err),     e.nerr);
      check_val({tag, "_sae"},    128'(a_sae),       e.sae);
      check_val({tag, "_sse"},    128'(a_sse),       e.sse);
      check_val({tag, "_maxae"},  128'(a_max_ae),    e.mae);
      check_val({tag, "_maxidx"}, 128'(a_max_idx),   e.midx);
      check_val({tag, "_ovf"},    128'(a_ovf),       e.ovf);
      check_val({tag, "_sae_n"},  128'(b_sae),       e.sae2);
      check_val({tag, "_sse_n"},  128'(b_sse),       e.sse2);
      check_val({tag, "_ovf_n"},  128'(b_ovf),       e.ovf2);
    end
  endtask

  // Drives one window from ap_a/ex_a with the valid pattern in vpat.
  task automatic run_window(input logic [31:0] wl, input string tag);
    int eff;
    int sent;
    int pi;
    int guard;
    bit v;
    bit xf;
    exp_t e;
    eff = (wl == 32'd0) ? 1 : int'(wl);
    e = model(eff);
    sb.push_back(e);
    start   = 1'b1;
    win_len = wl;
    cyc();
    start = 1'b0;
    check_val({tag, "_rdy_run"}, 128'(a_in_ready), 128'd1);
    sent = 0; pi = 0; guard = 0;
    while (sent < eff && guard < 200) begin
      v = (pi < vpat.size()) ? vpat[pi] : 1'b1;
      pi++;
      in_valid   = v;
      approx_sum = (sent < ap_a.size()) ? ap_a[sent] : 33'd0;
      exact_sum  = (sent < ex_a.size()) ? ex_a[sent] : 33'd0;
      start      = (misuse && guard == 1) ? 1'b1 : 1'b0;
      res_ack    = (misuse && guard == 1) ? 1'b1 : 1'b0;
      @(negedge Clk);
      xf = in_valid && a_in_ready;
      cyc();
      guard++;
      if (xf) sent++;
    end
    if (guard >= 200) check_val({tag, "_timeout"}, 128'(sent), 128'(eff));
    start   = 1'b0;
    res_ack = 1'b0;
    if (hold_valid) begin
      in_valid   = 1'b1;
      approx_sum = 33'd999;
      exact_sum  = 33'd0;
    end else begin
      in_valid = 1'b0;
    end
    check_val({tag, "_rdy_drop"}, 128'(a_in_ready), 128'd0);
    check_val({tag, "_done_c1"}, 128'(a_done), 128'd0);
    cyc();
    check_val({tag, "_done_c2"}, 128'(a_done), 128'd0);
    cyc();
    check_val({tag, "_done_c3"}, 128'(a_done), 128'd1);
    compare_results(tag);
    in_valid = 1'b0;
    res_ack  = 1'b1;
    cyc();
    res_ack = 1'b0;
    check_val({tag, "_done_ack"}, 128'(a_done), 128'd0);
    check_val({tag, "_held"}, 128'(a_n_samples), e.n);
    ap_a.delete();
    ex_a.delete();
    vpat.delete();
    misuse     = 1'b0;
    hold_valid = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_rdy"},   128'(a_in_ready),  128'd0);
    check_val({tag, "_done"},  128'(a_done),      128'd0);
    check_val({tag, "_nsamp"}, 128'(a_n_samples), 128'd0);
    check_val({tag, "_nerr"},  128'(a_n_err),     128'd0);
    check_val({tag, "_sae"},   128'(a_sae),       128'd0);
    check_val({tag, "_sse"},   128'(a_sse),       128'd0);
    check_val({tag, "_maxae"}, 128'(a_max_ae),    128'd0);
    check_val({tag, "_ovf"},   128'(a_ovf),       128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0; n_errors = 0;
    misuse = 1'b0; hold_valid = 1'b0;
    Rst = 1'b1; start = 1'b0; win_len = 32'd0; in_valid = 1'b0;
    approx_sum = 33'd0; exact_sum = 33'd0; res_ack = 1'b0;
    cyc(); cyc();
    Rst = 1'b0;
    check_zero("reset");

    // Exact match.
    for (int i = 0; i < 4; i++) begin ap_a.push_back(33'd100); ex_a.push_back(33'd100); end
    run_window(32'd4, "exact");

    // Mixed errors +3,-5,0,+5: tie at index 3 keeps index 1.
    ap_a = '{33'd1003, 33'd995, 33'd1000, 33'd1005};
    ex_a = '{33'd1000, 33'd1000, 33'd1000, 33'd1000};
    run_window(32'd4, "mixed");

    // Bubbles and an extra valid held after the window closes.
    ap_a = '{33'd10, 33'd20, 33'd30};
    ex_a = '{33'd12, 33'd20, 33'd27};
    vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    hold_valid = 1'b1;
    run_window(32'd3, "bubble");

    // Saturation on the narrow instance; the default instance fits.
    for (int i = 0; i < 8; i++) begin ap_a.push_back({1'b0, {32{1'b1}}} | 33'h1_0000_0000); ex_a.push_back(33'd0); end
    run_window(32'd8, "sat");

    // Reset after two of ten samples.
    start = 1'b1; win_len = 32'd10;
    cyc();
    start = 1'b0; in_valid = 1'b1; approx_sum = 33'd50; exact_sum = 33'd40;
    cyc();
    approx_sum = 33'd60;
    cyc();
    check_val("rstmid_live_cnt", 128'(a_n_samples), 128'd2);
    Rst = 1'b1; in_valid = 1'b0;
    cyc();
    Rst = 1'b0;
    check_zero("rstmid");
    cyc();
    check_zero("rstmid_flush");

    // Clean window after the abort.
    ap_a = '{33'd7, 33'd0, 33'd9};
    ex_a = '{33'd0, 33'd0, 33'd1};
    run_window(32'd3, "post_rst");

    // start and res_ack during RUN are ignored.
    ap_a = '{33'd5, 33'd1, 33'd8, 33'd2, 33'd4};
    ex_a = '{33'd1, 33'd5, 33'd8, 33'd9, 33'd4};
    misuse = 1'b1;
    run_window(32'd5, "misuse");

    // win_len = 0 behaves as a single-sample window.
    ap_a = '{33'd7};
    ex_a = '{33'd0};
    run_window(32'd0, "wl0");

    // Random window with random bubbles.
    for (int i = 0; i < 6; i++) begin
      ap_a.push_back({1'($urandom_range(0, 1)), 32'($urandom())});
      ex_a.push_back({1'($urandom_range(0, 1)), 32'($urandom())});
    end
    for (int i = 0; i < 10; i++) vpat.push_back(1'($urandom_range(0, 1)));
    run_window(32'd6, "rand");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
